ldm_stm_mem_transfer_sequencer: RTL and testbench
=================================================

// Module: ldm_stm_mem_transfer_sequencer
// PURPOSE
//  Memory-side sequencer for LDM/STM. Latches the 16-bit register list, base address and P/U/W/L
//  bits, then issues one memory request per set list bit, lowest register first, at ascending word addresses.
//  Counterpart of the register-side address generator. Drives the data-memory request interface,
//  the register-file write enable (LDM) and the base write-back (W=1).
// PARAMETERS
//  ADDR_WIDTH  32  width of base, memory and write-back addresses
//  WORD_BYTES   4  address step per transfer; N transfers span N*WORD_BYTES bytes
// PORTS
//  clk_in         in   1           clock, all state updates on rising edge
//  reset_in       in   1           synchronous, active-high reset
//  start_in       in   1           start pulse; sampled only in IDLE
//  reg_list_in    in   16          register list, bit i = Ri
//  base_addr_in   in   ADDR_WIDTH  base register value (Rn)
//  p_bit_in       in   1           1 = pre-index (before), 0 = post-index (after)
//  u_bit_in       in   1           1 = increment, 0 = decrement
//  w_bit_in       in   1           1 = write back final base
//  l_bit_in       in   1           1 = load (LDM), 0 = store (STM)
//  mem_ack_in     in   1           memory accepts current request this cycle
//  mem_req_out    out  1           request valid
//  mem_addr_out   out  ADDR_WIDTH  word address of current transfer
//  mem_we_out     out  1           1 = store; valid while mem_req_out=1
//  reg_addr_out   out  4           register of current transfer; valid while mem_req_out=1
//  reg_wr_en_out  out  1           mem_req_out & mem_ack_in & latched L (combinational)
//  busy_out       out  1           1 in every state except IDLE
//  done_out       out  1           one-cycle pulse in DONE
//  wb_en_out      out  1           one-cycle pulse in DONE when latched W=1
//  wb_addr_out    out  ADDR_WIDTH  final base value; valid while wb_en_out=1
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; latched list, count, address and mode bits cleared.
//  - FSM: IDLE -> SETUP -> XFER -> DONE -> IDLE. SETUP -> DONE directly when N=0.
//  - IDLE: start_in=1 latches all inputs. Next state SETUP. Later input changes are ignored until IDLE.
//  - SETUP (1 cycle): N = popcount(list). Start address S:
//      P0U1 (IA): base        P1U1 (IB): base+WB
//      P0U0 (DA): base-N*WB+WB    P1U0 (DB): base-N*WB      (WB=WORD_BYTES)
//    Final base F = U ? base+N*WB : base-N*WB. All arithmetic is modulo 2^ADDR_WIDTH; wrap is silent.
//  - XFER: mem_req_out=1. mem_addr_out and reg_addr_out (lowest remaining set bit) are held until ack.
//    On ack: clear that bit, mem_addr += WB. If it was the last bit, next state is DONE.
//    If ack stays high, transfers run back-to-back, one per cycle, with no idle cycle in between.
//  - Latency: start at edge t -> SETUP in cycle t+1 -> first mem_req_out in cycle t+2.
//  - DONE (1 cycle): done_out=1. wb_en_out=W. wb_addr_out=F. mem_req_out=0. Next state IDLE.
//    start_in in DONE is ignored.
//  - start_in while busy is ignored. mem_ack_in outside XFER is ignored.
//  - Empty list (N=0): no requests. done_out in cycle t+2. F = base.
//  - reset_in mid-operation: IDLE on the next edge, outputs 0, no done_out or wb_en_out, transfer abandoned.
//  - reg_wr_en_out never asserts for STM. mem_we_out = ~L during XFER, 0 otherwise.
// TESTING
//  1 IA LDM: base=0x1000, list=0x0015, P0 U1 W1 L1, ack=1 ->
//    (0x1000,r0),(0x1004,r2),(0x1008,r4) in consecutive cycles, reg_wr_en each,
//    then done + wb_en with wb_addr=0x100C.
//  2 DB STM: base=0x2000, list=0x8003, P1 U0 W1 L0 ->
//    (0x1FF4,r0),(0x1FF8,r1),(0x1FFC,r15), mem_we=1, reg_wr_en=0, wb_addr=0x1FF4.
//  3 Wait states: case 1 with ack low 3 cycles on first request ->
//    addr 0x1000 / r0 held stable 3 cycles, no reg_wr_en until ack.
//  4 Empty list: list=0x0000, W1 -> no mem_req, done_out at t+2, wb_addr=base.
//  5 Reset after 1 of 3 acks (case 1) -> IDLE next cycle, all outputs 0, no done_out;
//    next start runs fully correct.
//  6 Wrap and ignored start: IA base=0xFFFFFFFC, list=0x0003 -> addrs 0xFFFFFFFC, 0x00000000,
//    wb_addr=0x00000004; start_in pulsed during XFER has no effect.

Source files
------------

// File: rtl/ldm_stm_mem_transfer_sequencer.sv
// Memory-side LDM/STM sequencer: walks the latched register list lowest-first,
// issuing one word request per set bit, then reports the final base for write-back.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start_in; all outputs low
// ST_SETUP | compute transfer count, start address and final base
// ST_XFER  | present request for lowest remaining register until acked
// ST_DONE  | one-cycle done pulse, optional base write-back
module ldm_stm_mem_transfer_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  start_in,
    input  logic [15:0]           reg_list_in,
    input  logic [ADDR_WIDTH-1:0] base_addr_in,
    input  logic                  p_bit_in,
    input  logic                  u_bit_in,
    input  logic                  w_bit_in,
    input  logic                  l_bit_in,
    input  logic                  mem_ack_in,
    output logic                  mem_req_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic                  mem_we_out,
    output logic [3:0]            reg_addr_out,
    output logic                  reg_wr_en_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  wb_en_out,
    output logic [ADDR_WIDTH-1:0] wb_addr_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(WORD_BYTES);

    state_t                state, state_nxt;
    logic [15:0]           list_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] final_q;
    logic                  p_q, u_q, w_q, l_q;

    logic [4:0]            n_cnt;
    logic [3:0]            low_idx;
    logic [15:0]           list_clr;
    logic [ADDR_WIDTH-1:0] span;
    logic [ADDR_WIDTH-1:0] start_addr;

    // Scanning high to low leaves low_idx on the lowest set bit.
    always_comb begin
        n_cnt   = '0;
        low_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) begin
                n_cnt   = n_cnt + 5'd1;
                low_idx = 4'(i);
            end
        end
    end

    assign list_clr = list_q & ~(16'd1 << low_idx);
    assign span     = ADDR_WIDTH'(n_cnt) * STEP;

    always_comb begin
        case ({p_q, u_q})
            2'b01:   start_addr = base_q;
            2'b11:   start_addr = base_q + STEP;
            2'b00:   start_addr = base_q - span + STEP;
            default: start_addr = base_q - span;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            list_q  <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            final_q <= '0;
            p_q     <= 1'b0;
            u_q     <= 1'b0;
            w_q     <= 1'b0;
            l_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        list_q <= reg_list_in;
                        base_q <= base_addr_in;
                        p_q    <= p_bit_in;
                        u_q    <= u_bit_in;
                        w_q    <= w_bit_in;
                        l_q    <= l_bit_in;
                    end
                end
                ST_SETUP: begin
                    addr_q  <= start_addr;
                    final_q <= u_q ? (base_q + span) : (base_q - span);
                end
                ST_XFER: begin
                    if (mem_ack_in) begin
                        list_q <= list_clr;
                        addr_q <= addr_q + STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_in) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = (list_q == '0) ? ST_DONE : ST_XFER;
            ST_XFER:  if (mem_ack_in && list_clr == '0) state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_out  = 1'b0;
        mem_addr_out = '0;
        mem_we_out   = 1'b0;
        reg_addr_out = '0;
        done_out     = 1'b0;
        wb_en_out    = 1'b0;
        wb_addr_out  = '0;
        busy_out     = (state != ST_IDLE);
        case (state)
            ST_XFER: begin
                mem_req_out  = 1'b1;
                mem_addr_out = addr_q;
                mem_we_out   = ~l_q;
                reg_addr_out = low_idx;
            end
            ST_DONE: begin
                done_out    = 1'b1;
                wb_en_out   = w_q;
                wb_addr_out = final_q;
            end
            default: ;
        endcase
    end

    assign reg_wr_en_out = mem_req_out & mem_ack_in & l_q;

endmodule

// File: tb/tb_ldm_stm_mem_transfer_sequencer.sv
// Scoreboard bench for the LDM/STM sequencer: a list-walking reference model feeds
// expected transfers and done events; a negedge monitor compares what the DUT presents.
module tb_ldm_stm_mem_transfer_sequencer;

    localparam int AW = 32;
    localparam int WB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   reg_list;
    logic [AW-1:0] base_addr;
    logic          p_bit, u_bit, w_bit, l_bit;
    logic          mem_ack;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [3:0]    reg_addr;
    logic          reg_wr_en;
    logic          busy;
    logic          done;
    logic          wb_en;
    logic [AW-1:0] wb_addr;

    always #5 clk = ~clk;

    ldm_stm_mem_transfer_sequencer #(.ADDR_WIDTH(AW), .WORD_BYTES(WB)) dut (
        .clk_in        (clk),
        .reset_in      (rst),
        .start_in      (start),
        .reg_list_in   (reg_list),
        .base_addr_in  (base_addr),
        .p_bit_in      (p_bit),
        .u_bit_in      (u_bit),
        .w_bit_in      (w_bit),
        .l_bit_in      (l_bit),
        .mem_ack_in    (mem_ack),
        .mem_req_out   (mem_req),
        .mem_addr_out  (mem_addr),
        .mem_we_out    (mem_we),
        .reg_addr_out  (reg_addr),
        .reg_wr_en_out (reg_wr_en),
        .busy_out      (busy),
        .done_out      (done),
        .wb_en_out     (wb_en),
        .wb_addr_out   (wb_addr)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    r;
        logic          we;
        logic          wr;
    } xfer_t;

    typedef struct packed {
        logic          wb_en;
        logic [AW-1:0] wb_addr;
    } done_t;

    xfer_t exp_x[$];
    done_t exp_d[$];
    int    n_pass = 0;
    int    n_tot  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: N transfers at consecutive words from the mode-dependent start.
    task automatic model_push(input logic [AW-1:0] base, input logic [15:0] list,
                              input logic p, input logic u, input logic w, input logic l);
        int            n;
        int            k;
        logic [AW-1:0] span;
        logic [AW-1:0] s;
        xfer_t         x;
        done_t         d;
        n    = $countones(list);
        span = AW'(n * WB);
        if (u) s = p ? base + AW'(WB) : base;
        else   s = p ? base - span : base - span + AW'(WB);
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                x.addr = s + AW'(k * WB);
                x.r    = 4'(i);
                x.we   = ~l;
                x.wr   = l;
                exp_x.push_back(x);
                k++;
            end
        end
        d.wb_en   = w;
        d.wb_addr = u ? base + span : base - span;
        exp_d.push_back(d);
    endtask

    always @(negedge clk) begin
        xfer_t e;
        done_t d;
        if (!rst) begin
            if (mem_req) begin
                if (exp_x.size() == 0) begin
                    check("unexpected_req", 64'(mem_req), 64'd0);
                end else begin
                    e = exp_x[0];
                    check("mem_addr", 64'(mem_addr), 64'(e.addr));
                    check("reg_addr", 64'(reg_addr), 64'(e.r));
                    check("mem_we", 64'(mem_we), 64'(e.we));
                    check("reg_wr_en", 64'(reg_wr_en), mem_ack ? 64'(e.wr) : 64'd0);
                    if (mem_ack) void'(exp_x.pop_front());
                end
            end else begin
                check("reg_wr_en_noreq", 64'(reg_wr_en), 64'd0);
            end
            if (done) begin
                if (exp_d.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    d = exp_d.pop_front();
                    check("wb_en", 64'(wb_en), 64'(d.wb_en));
                    if (d.wb_en) check("wb_addr", 64'(wb_addr), 64'(d.wb_addr));
                    check("done_no_req", 64'(mem_req), 64'd0);
                end
            end else begin
                check("wb_en_nodone", 64'(wb_en), 64'd0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},    64'(mem_req), 64'd0);
        check({tag, "_addr"},   64'(mem_addr), 64'd0);
        check({tag, "_we"},     64'(mem_we), 64'd0);
        check({tag, "_reg"},    64'(reg_addr), 64'd0);
        check({tag, "_busy"},   64'(busy), 64'd0);
        check({tag, "_done"},   64'(done), 64'd0);
        check({tag, "_wb_en"},  64'(wb_en), 64'd0);
        check({tag, "_wb_addr"}, 64'(wb_addr), 64'd0);
    endtask

    // ack_mode: 0 = always ack, 1 = random ack, 2 = hold ack low 3 cycles first
    task automatic run_op(input logic [AW-1:0] base, input logic [15:0] list,
                          input logic p, input logic u, input logic w, input logic l,
                          input int ack_mode, input bit poke, input int reset_after);
        int cyc;
        int acks;
        bit finished;
        model_push(base, list, p, u, w, l);
        @(posedge clk) #1;
        start     = 1'b1;
        base_addr = base;
        reg_list  = list;
        p_bit     = p;
        u_bit     = u;
        w_bit     = w;
        l_bit     = l;
        mem_ack   = 1'b0;
        @(posedge clk) #1;
        start     = 1'b0;
        base_addr = $urandom;
        reg_list  = 16'($urandom);
        {p_bit, u_bit, w_bit, l_bit} = 4'($urandom);
        check("setup_busy", 64'(busy), 64'd1);
        check("setup_no_req", 64'(mem_req), 64'd0);
        @(posedge clk) #1;
        if (list == 16'd0) check("empty_done_latency", 64'(done), 64'd1);
        else               check("first_req_latency", 64'(mem_req), 64'd1);
        cyc      = 0;
        acks     = 0;
        finished = 1'b0;
        while (!finished && cyc < 200) begin
            if (reset_after >= 0 && acks == reset_after && mem_req) begin
                mem_ack = 1'b0;
                rst     = 1'b1;
                @(posedge clk) #1;
                rst = 1'b0;
                exp_x.delete();
                exp_d.delete();
                check_all_zero("after_reset");
                @(posedge clk) #1;
                check("reset_stays_idle", 64'(busy), 64'd0);
                return;
            end
            case (ack_mode)
                0:       mem_ack = 1'b1;
                1:       mem_ack = ($urandom_range(0, 3) != 0);
                default: mem_ack = (cyc >= 3);
            endcase
            if (mem_req && mem_ack) acks++;
            start = (poke && cyc == 1) || done;
            if (start) base_addr = $urandom;
            if (done) begin
                @(posedge clk) #1;
                start   = 1'b0;
                mem_ack = 1'b0;
                check("idle_after_done", 64'(busy), 64'd0);
                check("done_one_cycle", 64'(done), 64'd0);
                finished = 1'b1;
            end else begin
                @(posedge clk) #1;
                cyc++;
            end
        end
        start   = 1'b0;
        mem_ack = 1'b0;
        if (!finished) check("op_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        reg_list  = '0;
        base_addr = '0;
        {p_bit, u_bit, w_bit, l_bit} = 4'b0;
        mem_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_wr_en", 64'(reg_wr_en), 64'd0);
        rst = 1'b0;

        run_op(32'h0000_1000, 16'h0015, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, -1);
        run_op(32'h0000_2000, 16'h8003, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, -1);
        run_op(32'h0000_1000, 16'h0015, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b0, -1);
        run_op(32'h0000_3000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, -1);
        run_op(32'h0000_1000, 16'h0015, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1);
        run_op(32'h0000_1000, 16'h0015, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, -1);
        run_op(32'hFFFF_FFFC, 16'h0003, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b1, -1);
        run_op(32'h0000_4000, 16'h0021, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, -1);

        for (int t = 0; t < 30; t++) begin
            logic [15:0] lst;
            lst = 16'($urandom);
            if (t % 5 == 0) lst = 16'd0;
            else if (t % 3 == 0) lst = lst & 16'($urandom) & 16'($urandom);
            run_op($urandom, lst, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1, 1'($urandom), -1);
        end

        @(posedge clk) #1;
        check("leftover_xfers", 64'(exp_x.size()), 64'd0);
        check("leftover_dones", 64'(exp_d.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
